rgb_pwm_led_ctrl: RTL and testbench
===================================

RGB_PWM_LED_CTRL -- requirements
Module: rgb_pwm_led_ctrl

Interface
REQ-001 SHALL have parameter N_LEDS, default 25: number of RGB LEDs (1..64).
REQ-002 SHALL have parameter PWM_BITS, default 8: duty resolution in bits (2..16).
REQ-003 SHALL have parameter ADDR_W, default 7: word address width; must satisfy 2^ADDR_W >= 4+3*N_LEDS.
REQ-004 SHALL have clock and reset ports: `clk  in  1  single clock`; `reset  in  1  synchronous, active-high reset`.
REQ-005 SHALL have port `address  in  ADDR_W  Avalon-MM slave word address`.
REQ-006 SHALL have port `write  in  1  write strobe`.
REQ-007 SHALL have port `writedata  in  32  write data`.
REQ-008 SHALL have port `read  in  1  read strobe`.
REQ-009 SHALL have port `readdata  out  32  read data, fixed latency 1`.
REQ-010 SHALL have port `R  out  N_LEDS  red PWM outputs, bit i = LED i`.
REQ-011 SHALL have port `G  out  N_LEDS  green PWM outputs`.
REQ-012 SHALL have port `B  out  N_LEDS  blue PWM outputs`.

Function
REQ-013 SHALL implement this register map:
- addr 0 CTRL: bit0 ENABLE (rw); bit1 COMMIT (write-1 sets pending, reads 0).
- addr 1 PRESCALE: bits[15:0] (rw).
- addr 2 STATUS: bit0 PENDING (ro).
- addr 3: reserved, reads 0.
- addr 4+3*i+c: shadow duty for LED i, colour c (0=R, 1=G, 2=B), bits[PWM_BITS-1:0] (rw).
REQ-014 SHALL ignore writes to unmapped or read-only addresses, and SHALL return 0 on reads of unmapped addresses and of unused upper bits.
REQ-015 SHALL present readdata the cycle after read is asserted, and SHALL hold readdata otherwise.
REQ-016 SHALL hold each shadow duty register and a separate active duty register per LED/colour; PWM compares only against active registers.
REQ-017 SHALL generate a tick every PRESCALE+1 clk cycles while ENABLE=1; PRESCALE=0 gives a tick every cycle.
REQ-018 SHALL advance a PWM counter on each tick, counting 0..2^PWM_BITS-2 and then wrapping to 0; the period is 2^PWM_BITS-1 ticks.
REQ-019 SHALL register outputs: output = (counter < active duty), one clk cycle after the counter value.
- duty 0: constantly low.
- duty 2^PWM_BITS-1: constantly high.
REQ-020 SHALL, with COMMIT pending, copy all shadow registers into active registers in the cycle the counter wraps to 0, and SHALL clear PENDING in that same cycle.
REQ-021 SHALL, when a shadow write coincides with a commit copy, copy the pre-write shadow value; the new value waits for the next commit.
REQ-022 SHALL, when a COMMIT write coincides with a wrap, defer the copy to the following wrap.
REQ-023 SHALL, while ENABLE=0:
- hold the prescaler and PWM counter at 0;
- drive R/G/B to 0;
- apply a pending commit on the next cycle.
REQ-024 SHALL restart the prescaler and counter from 0 when ENABLE goes 0->1, so the first tick occurs PRESCALE+1 cycles later.
REQ-025 SHALL apply a PRESCALE write from the next tick boundary, without glitching the current tick interval.
REQ-026 SHALL leave repeated COMMIT writes while PENDING is set idempotent (a single copy).

Reset
REQ-027 SHALL, on reset, clear CTRL, PRESCALE, PENDING, all shadow and active duty registers, the prescaler, the counter, R/G/B and readdata to 0.
REQ-028 SHALL abort an in-progress period and discard a pending commit when reset is asserted mid-operation.

Verification (N_LEDS=25, PWM_BITS=8)
REQ-029 SHALL verify commit on the period boundary:
- Stimulus: PRESCALE=0, duty LED0 R=64, COMMIT, ENABLE=1.
- Response: first period unchanged (R[0]=0); from the next period R[0] is high 64 of every 255 cycles, and PENDING reads 0 after the wrap.
REQ-030 SHALL verify the duty extremes:
- Stimulus: duty LED24 B=255, duty LED24 G=0, commit, enable.
- Response: B[24] constantly 1 and G[24] constantly 0 across 3 periods.
REQ-031 SHALL verify the prescaler:
- Stimulus: PRESCALE=3, duty LED5 G=128.
- Response: period = 1020 cycles; G[5] high for 512 cycles.
REQ-032 SHALL verify the coincident shadow write:
- Stimulus: shadow write of 200 in the exact commit-copy cycle, with the prior shadow value 10.
- Response: active duty is 10; 200 takes effect only after the next COMMIT plus wrap.
REQ-033 SHALL verify disable and the register file:
- Stimulus: ENABLE=0 mid-period.
- Response: outputs are 0 within 1 cycle; a pending commit is applied next cycle.
- Also check: unmapped address 0x7F reads 0; readdata latency is exactly 1.
REQ-034 SHALL verify reset mid-period:
- Stimulus: reset mid-period with PENDING=1.
- Response: all outputs, registers and STATUS read 0 afterwards.

Source files
------------

// File: rtl/rgb_pwm_led_ctrl.sv
// RGB PWM LED controller with an Avalon-MM register file.
// Duties are written into shadow registers and copied into the active set
// on COMMIT. The copy happens at a PWM period boundary, or on the next
// cycle while the controller is disabled.
module rgb_pwm_led_ctrl #(
  parameter int unsigned N_LEDS   = 25,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic              read,
  output logic [31:0]       readdata,
  output logic [N_LEDS-1:0] R,
  output logic [N_LEDS-1:0] G,
  output logic [N_LEDS-1:0] B
);

  localparam int unsigned N_DUTY = 3 * N_LEDS;
  localparam int unsigned IDX_W  = (N_DUTY > 1) ? $clog2(N_DUTY) : 1;
  // Last counter value before the wrap: 2^PWM_BITS-2.
  localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS - 1){1'b1}}, 1'b0};

  // Control / status state
  logic                r_enable;
  logic [15:0]         r_prescale;
  logic                r_pending;
  // Timebase state
  logic [15:0]         r_presc_cnt;
  logic [15:0]         r_presc_act;  // prescale value in force for the current tick interval
  logic [PWM_BITS-1:0] r_cnt;
  // Duty storage: index 3*led + colour
  logic [PWM_BITS-1:0] r_shadow [N_DUTY];
  logic [PWM_BITS-1:0] r_active [N_DUTY];
  // Registered outputs
  logic [N_LEDS-1:0]   r_r, r_g, r_b;
  logic [31:0]         r_readdata;

  logic [31:0]         w_addr32;
  logic                w_is_duty;
  logic [IDX_W-1:0]    w_idx;
  logic                w_wr_ctrl, w_wr_presc, w_wr_duty, w_commit_wr;
  logic                w_enable_d, w_run;
  logic                w_tick, w_wrap, w_copy;
  logic [31:0]         w_rdata;
  logic                w_unused_wdata;

  assign w_addr32       = 32'(address);
  assign w_is_duty      = (w_addr32 >= 32'd4) && (w_addr32 < 32'(4 + N_DUTY));
  assign w_idx          = IDX_W'(address - ADDR_W'(4));
  assign w_unused_wdata = ^writedata[31:16];

  assign w_wr_ctrl   = write && (address == ADDR_W'(0));
  assign w_wr_presc  = write && (address == ADDR_W'(1));
  assign w_wr_duty   = write && w_is_duty;
  assign w_commit_wr = w_wr_ctrl && writedata[1];

  // Outputs drop in the same edge that ENABLE clears, not one cycle later.
  assign w_enable_d = w_wr_ctrl ? writedata[0] : r_enable;
  assign w_run      = r_enable && w_enable_d;

  assign w_tick = r_enable && (r_presc_cnt == r_presc_act);
  assign w_wrap = w_tick && (r_cnt == CNT_LAST);
  // Copy uses the registered PENDING, so a COMMIT landing on a wrap waits a period.
  assign w_copy = r_pending && (w_wrap || !r_enable);

  // Read mux; unmapped addresses and unused bits read as zero
  always_comb begin
    w_rdata = '0;
    if (w_is_duty) begin
      w_rdata = 32'(r_shadow[w_idx]);
    end else if (address == ADDR_W'(0)) begin
      w_rdata[0] = r_enable;
    end else if (address == ADDR_W'(1)) begin
      w_rdata[15:0] = r_prescale;
    end else if (address == ADDR_W'(2)) begin
      w_rdata[0] = r_pending;
    end
  end

  // CTRL, PRESCALE and PENDING; a new COMMIT wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable   <= 1'b0;
      r_prescale <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= writedata[0];
      end
      if (w_wr_presc) begin
        r_prescale <= writedata[15:0];
      end
      if (w_commit_wr) begin
        r_pending <= 1'b1;
      end else if (w_copy) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Prescaler and PWM counter; both held at zero while disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc_cnt <= '0;
      r_presc_act <= '0;
      r_cnt       <= '0;
    end else if (!r_enable) begin
      r_presc_cnt <= '0;
      r_presc_act <= r_prescale;
      r_cnt       <= '0;
    end else if (w_tick) begin
      r_presc_cnt <= '0;
      r_presc_act <= r_prescale;
      r_cnt       <= w_wrap ? '0 : r_cnt + PWM_BITS'(1);
    end else begin
      r_presc_cnt <= r_presc_cnt + 16'd1;
    end
  end

  // Shadow writes and commit copy; active takes the pre-write shadow value
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(N_DUTY); i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_copy) begin
        for (int i = 0; i < int'(N_DUTY); i++) begin
          r_active[i] <= r_shadow[i];
        end
      end
      if (w_wr_duty) begin
        r_shadow[w_idx] <= writedata[PWM_BITS-1:0];
      end
    end
  end

  // PWM compare against the active duties, registered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_r <= '0;
      r_g <= '0;
      r_b <= '0;
    end else begin
      for (int i = 0; i < int'(N_LEDS); i++) begin
        r_r[i] <= w_run && (r_cnt < r_active[3*i]);
        r_g[i] <= w_run && (r_cnt < r_active[3*i+1]);
        r_b[i] <= w_run && (r_cnt < r_active[3*i+2]);
      end
    end
  end

  // Read data with one cycle latency, held between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (read) begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign R        = r_r;
  assign G        = r_g;
  assign B        = r_b;

endmodule

// File: tb/tb_rgb_pwm_led_ctrl.sv
// Scoreboard bench for rgb_pwm_led_ctrl: a behavioural model predicts every
// read response and the per-cycle R/G/B vectors; a monitor compares them.
module tb_rgb_pwm_led_ctrl;

  localparam int N      = 25;
  localparam int PB     = 8;
  localparam int AW     = 7;
  localparam int ND     = 3 * N;
  localparam int PERIOD = (1 << PB) - 1;

  logic          clk = 1'b0;
  logic          reset, write, read;
  logic [AW-1:0] address;
  logic [31:0]   writedata, readdata;
  logic [N-1:0]  R, G, B;

  always #5 clk = ~clk;

  rgb_pwm_led_ctrl #(.N_LEDS(N), .PWM_BITS(PB), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .read      (read),
    .readdata  (readdata),
    .R         (R),
    .G         (G),
    .B         (B)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues
  logic [31:0] rq[$];                      // expected read responses
  string       dq_name[$];                 // directed measurements
  logic [31:0] dq_act[$];
  logic [31:0] dq_exp[$];

  // Reference model state
  bit          m_valid = 1'b0;
  bit          m_en, m_pend;
  int          m_presc, m_ilen, m_phase, m_pos;
  int          m_shadow[ND];
  int          m_active[ND];
  logic [N-1:0] m_r, m_g, m_b;

  // One clock of the reference model, evaluated on the inputs seen at this edge
  task automatic model_step();
    logic [31:0] rexp;
    bit en_next, tick, wrap, copy;
    int a;
    if (reset) begin
      m_en = 0; m_pend = 0; m_presc = 0; m_ilen = 1; m_phase = 0; m_pos = 0;
      for (int i = 0; i < ND; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
      m_r = '0; m_g = '0; m_b = '0;
      m_valid = 1'b1;
      return;
    end
    a = int'(address);
    if (read) begin
      rexp = 32'd0;
      if (a == 0)                    rexp = {31'd0, m_en};
      else if (a == 1)               rexp = 32'(m_presc);
      else if (a == 2)               rexp = {31'd0, m_pend};
      else if (a >= 4 && a < 4 + ND) rexp = 32'(m_shadow[a-4]);
      rq.push_back(rexp);
    end
    en_next = (write && a == 0) ? writedata[0] : m_en;
    tick    = m_en && (m_phase == m_ilen - 1);
    wrap    = tick && (m_pos == PERIOD - 1);
    copy    = m_pend && (wrap || !m_en);
    for (int i = 0; i < N; i++) begin
      m_r[i] = m_en && en_next && (m_pos < m_active[3*i]);
      m_g[i] = m_en && en_next && (m_pos < m_active[3*i+1]);
      m_b[i] = m_en && en_next && (m_pos < m_active[3*i+2]);
    end
    if (!m_en) begin
      m_phase = 0; m_pos = 0; m_ilen = m_presc + 1;
    end else if (tick) begin
      m_phase = 0; m_ilen = m_presc + 1; m_pos = (m_pos + 1) % PERIOD;
    end else begin
      m_phase++;
    end
    if (copy) begin
      for (int i = 0; i < ND; i++) m_active[i] = m_shadow[i];
      m_pend = 0;
    end
    if (write) begin
      if (a == 0) begin
        m_en = writedata[0];
        if (writedata[1]) m_pend = 1;
      end else if (a == 1) begin
        m_presc = int'(writedata[15:0]);
      end else if (a >= 4 && a < 4 + ND) begin
        m_shadow[a-4] = int'(writedata[PB-1:0]);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: all comparisons happen here
  initial forever begin
    logic [31:0] e, act;
    string n;
    @(negedge clk);
    if (m_valid) begin
      checks++;
      if ({R, G, B} !== {m_r, m_g, m_b}) begin
        failures++;
        $display("FAIL pwm_out t=%0t got R=%h G=%h B=%h want R=%h G=%h B=%h",
                 $time, R, G, B, m_r, m_g, m_b);
      end
    end
    if (rq.size() != 0) begin
      e = rq.pop_front();
      checks++;
      if (readdata !== e) begin
        failures++;
        $display("FAIL readdata t=%0t got %h want %h", $time, readdata, e);
      end
    end
    while (dq_name.size() != 0) begin
      n   = dq_name.pop_front();
      act = dq_act.pop_front();
      e   = dq_exp.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s t=%0t got %0d want %0d", n, $time, act, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    dq_name.push_back(n);
    dq_act.push_back(act);
    dq_exp.push_back(exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the write is sampled at the following posedge
  task automatic bus_wr(input int a, input logic [31:0] d);
    address = AW'(a); writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0; address = AW'($urandom); writedata = $urandom;
  endtask

  task automatic bus_rd(input int a);
    address = AW'(a); read = 1'b1;
    @(negedge clk);
    read = 1'b0; address = AW'($urandom);
  endtask

  task automatic count_hi(input int ncyc, input int led, output int rc, output int gc,
                          output int bc);
    rc = 0; gc = 0; bc = 0;
    repeat (ncyc) begin
      @(negedge clk);
      rc += int'(R[led]); gc += int'(G[led]); bc += int'(B[led]);
    end
  endtask

  // Wait (bounded) until the model sits at counter value p with a tick due next edge
  task automatic wait_pos(input int p, input int maxc, input string n);
    int k = 0;
    while (!(m_en && m_ilen == 1 && m_pos == p) && k < maxc) begin
      @(negedge clk);
      k++;
    end
    push_chk(n, 32'(k < maxc), 32'd1);
  endtask

  initial begin
    int rc, gc, bc, r, a;
    logic [31:0] d;
    reset = 1'b1; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
    cycles(3);
    reset = 1'b0;
    push_chk("reset_readdata", readdata, 32'd0);
    for (int i = 0; i < 8; i++) bus_rd(i);
    bus_rd(78);

    // Commit lands on the period boundary
    bus_wr(4, 32'd64);
    bus_wr(0, 32'd3);
    count_hi(PERIOD, 0, rc, gc, bc);
    push_chk("first_period_r0", 32'(rc), 32'd0);
    count_hi(PERIOD, 0, rc, gc, bc);
    push_chk("duty64_r0", 32'(rc), 32'd64);
    bus_rd(2);
    push_chk("pending_after_wrap", readdata, 32'd0);

    // Duty extremes
    bus_wr(78, 32'd255);
    bus_wr(77, 32'd0);
    bus_wr(0, 32'd3);
    cycles(2 * PERIOD + 5);
    count_hi(3 * PERIOD, 24, rc, gc, bc);
    push_chk("b24_full", 32'(bc), 32'(3 * PERIOD));
    push_chk("g24_zero", 32'(gc), 32'd0);

    // Prescaler
    bus_wr(20, 32'd128);
    bus_wr(1, 32'd3);
    bus_wr(0, 32'd3);
    cycles(2 * 4 * PERIOD + 20);
    count_hi(4 * PERIOD, 5, rc, gc, bc);
    push_chk("g5_presc3", 32'(gc), 32'd512);
    count_hi(4 * PERIOD, 0, rc, gc, bc);
    push_chk("r0_presc3", 32'(rc), 32'd256);

    // Shadow write coinciding with the commit copy
    bus_wr(1, 32'd0);
    cycles(10);
    bus_wr(4, 32'd10);
    bus_wr(0, 32'd3);
    wait_pos(PERIOD - 1, 3000, "wait_copy_wrap");
    bus_wr(4, 32'd200);
    count_hi(PERIOD, 0, rc, gc, bc);
    push_chk("coincident_active10", 32'(rc), 32'd10);
    bus_rd(4);
    push_chk("shadow_holds_200", readdata, 32'd200);
    bus_wr(0, 32'd3);
    cycles(2 * PERIOD + 10);
    count_hi(PERIOD, 0, rc, gc, bc);
    push_chk("after_commit_200", 32'(rc), 32'd200);

    // Disable mid-period with a pending commit, then register file corners
    wait_pos(20, 1000, "wait_mid_period");
    bus_wr(4, 32'd50);
    bus_wr(0, 32'd3);
    cycles(20);
    bus_wr(0, 32'd0);
    push_chk("disable_out_zero", 32'(|{R, G, B}), 32'd0);
    cycles(1);
    bus_rd(2);
    push_chk("disable_commit_applied", readdata, 32'd0);
    bus_wr(127, $urandom);
    bus_rd(127);
    push_chk("unmapped_7f", readdata, 32'd0);
    bus_wr(2, 32'hFFFF_FFFF);
    bus_rd(2);
    push_chk("status_ro", readdata, 32'd0);
    bus_wr(3, 32'hFFFF_FFFF);
    bus_rd(3);
    bus_wr(1, 32'hABCD_0002);
    address = AW'(1); read = 1'b1;
    @(negedge clk);
    read = 1'b0; address = AW'(2);
    push_chk("rd_latency1", readdata, 32'd2);
    @(negedge clk);
    push_chk("rd_hold", readdata, 32'd2);
    bus_wr(1, 32'd0);
    bus_wr(0, 32'd1);
    cycles(PERIOD + 10);
    count_hi(PERIOD, 0, rc, gc, bc);
    push_chk("reenable_r0_50", 32'(rc), 32'd50);

    // Reset mid-period with a commit pending
    bus_wr(4, 32'd99);
    bus_wr(0, 32'd3);
    cycles(30);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    push_chk("reset_out_zero", 32'(|{R, G, B}), 32'd0);
    push_chk("reset_rd_zero", readdata, 32'd0);
    bus_rd(2);
    push_chk("reset_status", readdata, 32'd0);
    bus_rd(0);
    push_chk("reset_ctrl", readdata, 32'd0);
    bus_rd(4);
    bus_rd(20);
    bus_rd(78);
    bus_wr(0, 32'd1);
    count_hi(2 * PERIOD + 10, 0, rc, gc, bc);
    push_chk("reset_r0_dark", 32'(rc), 32'd0);
    count_hi(PERIOD, 24, rc, gc, bc);
    push_chk("reset_b24_dark", 32'(bc), 32'd0);

    // Randomised traffic against the model
    for (int it = 0; it < 3000; it++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        cycles(1);
      end else if (r < 75) begin
        a = $urandom_range(0, 127);
        d = $urandom;
        if (a == 1) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
        if (a == 0) d[0] = ($urandom_range(0, 3) != 0);
        if (a >= 4 && a < 4 + ND && $urandom_range(0, 3) == 0) d[7:0] = d[0] ? 8'hFF : 8'h00;
        bus_wr(a, d);
      end else if (r < 90) begin
        bus_rd($urandom_range(0, 127));
      end else begin
        d = 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
        bus_wr(0, d);
      end
    end

    cycles(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
